// File: rtl/clocks_ctrl_pkg.sv
// clocks_ctrl_pkg: supervisor state encodings and default bring-up timing constants.
package clocks_ctrl_pkg;

    typedef enum logic [2:0] {
        MMCM_RST  = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        IDLY_RST  = 3'd3,
        WAIT_IDLY = 3'd4,
        READY     = 3'd5,
        FAIL      = 3'd6
    } sup_state_e;

    localparam int DEF_MMCM_RST_CYCLES = 8;
    localparam int DEF_LOCK_TIMEOUT    = 65535;
    localparam int DEF_STABLE_CYCLES   = 1024;
    localparam int DEF_IDLY_RST_CYCLES = 16;
    localparam int DEF_IDLY_TIMEOUT    = 1024;
    localparam int DEF_MAX_RETRIES     = 3;
    localparam int DEF_CNT_W           = 16;

endpackage

// File: rtl/sync_block.sv
// sync_block: two-flop synchroniser for a single asynchronous level.
module sync_block (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/mmcm_lock_supervisor.sv
// mmcm_lock_supervisor: sequences MMCM reset/lock and IDELAYCTRL reset/ready,
// with timeouts, bounded retries, lock-loss restart and sticky failure status.
module mmcm_lock_supervisor
    import clocks_ctrl_pkg::*;
#(
    parameter int MMCM_RST_CYCLES = DEF_MMCM_RST_CYCLES,
    parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES   = DEF_STABLE_CYCLES,
    parameter int IDLY_RST_CYCLES = DEF_IDLY_RST_CYCLES,
    parameter int IDLY_TIMEOUT    = DEF_IDLY_TIMEOUT,
    parameter int MAX_RETRIES     = DEF_MAX_RETRIES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       glbl_rst,
    input  logic       mmcm_locked,
    input  logic       idelayctrl_rdy,
    input  logic       restart,
    output logic       mmcm_rst,
    output logic       idelayctrl_rst,
    output logic       clocks_ready,
    output logic       fail,
    output logic [1:0] retry_cnt,
    output logic [2:0] state_dbg
);

    localparam logic [CNT_W-1:0] T_MRST   = CNT_W'(MMCM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] T_LOCK   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] T_STABLE = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] T_IRST   = CNT_W'(IDLY_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] T_IDLY   = CNT_W'(IDLY_TIMEOUT - 1);
    localparam logic [1:0]       MAXR     = 2'(MAX_RETRIES);

    logic             locked_s, rdy_s, failure;
    sup_state_e       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [1:0]       retry_q, retry_d;
    logic             fail_q, fail_d, mmcm_rst_q, mmcm_rst_d;
    logic             idly_rst_q, idly_rst_d, ready_q, ready_d;

    sync_block u_sync_lock (.clk(clk), .rst(glbl_rst), .d(mmcm_locked),    .q(locked_s));
    sync_block u_sync_rdy  (.clk(clk), .rst(glbl_rst), .d(idelayctrl_rdy), .q(rdy_s));

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        fail_d  = fail_q;
        failure = 1'b0;
        case (state_q)
            MMCM_RST:  if (timer_q == T_MRST) state_d = WAIT_LOCK;
            WAIT_LOCK: if (locked_s) state_d = STABLE; else if (timer_q == T_LOCK) failure = 1'b1;
            STABLE:    if (!locked_s) failure = 1'b1; else if (timer_q == T_STABLE) state_d = IDLY_RST;
            IDLY_RST:  if (!locked_s) failure = 1'b1; else if (timer_q == T_IRST) state_d = WAIT_IDLY;
            WAIT_IDLY: if (!locked_s || (!rdy_s && timer_q == T_IDLY)) failure = 1'b1;
                       else if (rdy_s) state_d = READY;
            READY:     if (!locked_s) state_d = MMCM_RST;
            FAIL:      ;
            default:   state_d = MMCM_RST;
        endcase
        if (failure) begin
            state_d = (retry_q < MAXR) ? MMCM_RST : FAIL;
            retry_d = (retry_q < MAXR) ? retry_q + 2'd1 : retry_q;
            fail_d  = !(retry_q < MAXR);
        end
        if (state_d == READY && state_q != READY) retry_d = '0;
        if (restart) begin
            state_d = MMCM_RST;
            retry_d = '0;
            fail_d  = 1'b0;
        end
        // Saturate rather than wrap so a stuck state can never alias a short timeout.
        timer_d    = (restart || state_d != state_q) ? '0 : (&timer_q ? timer_q : timer_q + 1'b1);
        mmcm_rst_d = state_d == MMCM_RST || state_d == FAIL;
        idly_rst_d = state_d == MMCM_RST || state_d == IDLY_RST;
        ready_d    = state_d == READY;
    end

    always_ff @(posedge clk or posedge glbl_rst) begin
        if (glbl_rst) begin
            state_q    <= MMCM_RST;
            timer_q    <= '0;
            retry_q    <= '0;
            fail_q     <= 1'b0;
            mmcm_rst_q <= 1'b1;
            idly_rst_q <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            fail_q     <= fail_d;
            mmcm_rst_q <= mmcm_rst_d;
            idly_rst_q <= idly_rst_d;
            ready_q    <= ready_d;
        end
    end

    assign mmcm_rst       = mmcm_rst_q;
    assign idelayctrl_rst = idly_rst_q;
    assign clocks_ready   = ready_q;
    assign fail           = fail_q;
    assign retry_cnt      = retry_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_mmcm_lock_supervisor.sv
// tb_mmcm_lock_supervisor: scoreboard of expected output snapshots (and their
// durations) checked by a monitor on every output change, plus directed spot checks.
module tb_mmcm_lock_supervisor;

    logic       clk = 1'b0;
    logic       glbl_rst, mmcm_locked, idelayctrl_rdy, restart;
    logic       mmcm_rst, idelayctrl_rst, clocks_ready, fail;
    logic [1:0] retry_cnt;
    logic [2:0] state_dbg;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    int         dur_q[$];
    logic [8:0] last, cur, e;
    int         dur, d;
    bit         mon_en = 1'b0;
    bit         mon_init = 1'b0;

    always #5 clk = ~clk;

    mmcm_lock_supervisor #(
        .MMCM_RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8),
        .IDLY_RST_CYCLES(4), .IDLY_TIMEOUT(10), .MAX_RETRIES(2), .CNT_W(16)
    ) dut (
        .clk(clk), .glbl_rst(glbl_rst), .mmcm_locked(mmcm_locked),
        .idelayctrl_rdy(idelayctrl_rdy), .restart(restart),
        .mmcm_rst(mmcm_rst), .idelayctrl_rst(idelayctrl_rst),
        .clocks_ready(clocks_ready), .fail(fail),
        .retry_cnt(retry_cnt), .state_dbg(state_dbg)
    );

    function automatic logic [8:0] snap();
        return {state_dbg, mmcm_rst, idelayctrl_rst, clocks_ready, fail, retry_cnt};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    // Expected snapshot {state, mmcm_rst, idelayctrl_rst, clocks_ready, fail, retry}
    // plus how many cycles the previous snapshot must have lasted (-1: any).
    task automatic push(input logic [2:0] st, input logic mr, input logic ir, input logic cr,
                        input logic f, input logic [1:0] rc, input int dd);
        exp_q.push_back({st, mr, ir, cr, f, rc});
        dur_q.push_back(dd);
    endtask

    task automatic push_bringup(input logic [1:0] rc, input int d0);
        push(3'd1, 0, 0, 0, 0, rc, d0);
        push(3'd2, 0, 0, 0, 0, rc, -1);
        push(3'd3, 0, 1, 0, 0, rc, 8);
        push(3'd4, 0, 0, 0, 0, rc, 4);
        push(3'd5, 0, 0, 1, 0, 2'd0, -1);
    endtask

    task automatic wait_state(input logic [2:0] s, input int max);
        int n = 0;
        while (state_dbg !== s && n < max) begin
            @(negedge clk);
            n++;
        end
        if (state_dbg !== s) begin
            checks++;
            errors++;
            $display("FAIL wait_state: got state %0d required %0d", state_dbg, s);
        end
    endtask

    task automatic drive_bringup();
        wait_state(3'd1, 40);
        repeat (5) @(negedge clk);
        mmcm_locked = 1'b1;
        wait_state(3'd4, 60);
        repeat (3) @(negedge clk);
        idelayctrl_rdy = 1'b1;
        wait_state(3'd5, 40);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            cur = snap();
            if (!mon_init) begin
                last = cur;
                dur = 1;
                mon_init = 1'b1;
            end else if (cur !== last) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_change: got %b required no change from %b", cur, last);
                end else begin
                    e = exp_q.pop_front();
                    d = dur_q.pop_front();
                    check("snapshot", 32'(cur), 32'(e));
                    if (d >= 0) check("duration", dur, d);
                end
                last = cur;
                dur = 1;
            end else begin
                dur++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        glbl_rst = 1'b1;
        mmcm_locked = 1'b0;
        idelayctrl_rdy = 1'b0;
        restart = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mmcm_rst", mmcm_rst, 1);
        check("rst_idly_rst", idelayctrl_rst, 1);
        check("rst_ready", clocks_ready, 0);
        check("rst_fail", fail, 0);
        check("rst_retry", retry_cnt, 0);
        check("rst_state", state_dbg, 0);
        glbl_rst = 1'b0;
        mon_en = 1'b1;
        // Nominal bring-up
        push_bringup(2'd0, -1);
        drive_bringup();
        // Lock loss in READY
        push(3'd0, 1, 1, 0, 0, 2'd0, -1);
        push_bringup(2'd0, 4);
        mmcm_locked = 1'b0;
        idelayctrl_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("ready_hold", clocks_ready, 1);
        @(posedge clk);
        #1 check("ready_drop", clocks_ready, 0);
        check("lockloss_retry", retry_cnt, 0);
        drive_bringup();
        // Lock glitch during STABLE
        @(negedge clk);
        mmcm_locked = 1'b0;
        idelayctrl_rdy = 1'b0;
        restart = 1'b1;
        push(3'd0, 1, 1, 0, 0, 2'd0, -1);
        push(3'd1, 0, 0, 0, 0, 2'd0, 4);
        push(3'd2, 0, 0, 0, 0, 2'd0, -1);
        push(3'd0, 1, 1, 0, 0, 2'd1, -1);
        push_bringup(2'd1, 4);
        @(negedge clk);
        restart = 1'b0;
        wait_state(3'd1, 20);
        repeat (5) @(negedge clk);
        mmcm_locked = 1'b1;
        wait_state(3'd2, 20);
        repeat (2) @(negedge clk);
        mmcm_locked = 1'b0;
        repeat (3) @(negedge clk);
        drive_bringup();
        // Lock never asserts: three attempts then FAIL
        @(negedge clk);
        mmcm_locked = 1'b0;
        idelayctrl_rdy = 1'b0;
        restart = 1'b1;
        push(3'd0, 1, 1, 0, 0, 2'd0, -1);
        push(3'd1, 0, 0, 0, 0, 2'd0, 4);
        push(3'd0, 1, 1, 0, 0, 2'd1, 20);
        push(3'd1, 0, 0, 0, 0, 2'd1, 4);
        push(3'd0, 1, 1, 0, 0, 2'd2, 20);
        push(3'd1, 0, 0, 0, 0, 2'd2, 4);
        push(3'd6, 1, 0, 0, 1, 2'd2, 20);
        @(negedge clk);
        restart = 1'b0;
        wait_state(3'd6, 150);
        repeat (5) @(negedge clk);
        check("fail_sticky", fail, 1);
        check("fail_mmcm_rst", mmcm_rst, 1);
        check("fail_ready", clocks_ready, 0);
        check("fail_retry", retry_cnt, 2);
        // Restart out of FAIL
        restart = 1'b1;
        push(3'd0, 1, 1, 0, 0, 2'd0, -1);
        push_bringup(2'd0, 4);
        @(posedge clk);
        #1 check("restart_state", state_dbg, 0);
        check("restart_fail", fail, 0);
        check("restart_retry", retry_cnt, 0);
        @(negedge clk);
        restart = 1'b0;
        drive_bringup();
        // Asynchronous glbl_rst while waiting for IDELAYCTRL
        @(negedge clk);
        mmcm_locked = 1'b0;
        idelayctrl_rdy = 1'b0;
        restart = 1'b1;
        push(3'd0, 1, 1, 0, 0, 2'd0, -1);
        push(3'd1, 0, 0, 0, 0, 2'd0, 4);
        push(3'd2, 0, 0, 0, 0, 2'd0, -1);
        push(3'd3, 0, 1, 0, 0, 2'd0, 8);
        push(3'd4, 0, 0, 0, 0, 2'd0, 4);
        push(3'd0, 1, 1, 0, 0, 2'd0, -1);
        push(3'd1, 0, 0, 0, 0, 2'd0, -1);
        @(negedge clk);
        restart = 1'b0;
        wait_state(3'd1, 20);
        repeat (5) @(negedge clk);
        mmcm_locked = 1'b1;
        wait_state(3'd4, 40);
        #1 glbl_rst = 1'b1;
        mmcm_locked = 1'b0;
        #1 check("arst_mmcm_rst", mmcm_rst, 1);
        check("arst_idly_rst", idelayctrl_rst, 1);
        check("arst_ready", clocks_ready, 0);
        check("arst_state", state_dbg, 0);
        repeat (2) @(negedge clk);
        glbl_rst = 1'b0;
        wait_state(3'd1, 20);
        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
